// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared types for the memory access unit:
//   mem_size_e  - access size encoding as carried on ExMe_out_mem_size
//   mem_state_e - bus transaction FSM states
//   size_bytes  - number of bytes touched by an access of a given size
// ---------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    HALF  = 2'b01,
    WORD  = 2'b10,
    DWORD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  function automatic logic [3:0] size_bytes(input mem_size_e size);
    case (size)
      BYTE:    return 4'd1;
      HALF:    return 4'd2;
      WORD:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Purely combinational lane steering between the pipeline and the data bus.
// Store side: replicates the right-justified store datum across every lane
// of its size and produces the byte enables for the addressed lane.
// Load side: extracts the addressed lane from the bus read data and sign- or
// zero-extends it to DATA_W.
// Ports:
//   i_size      access size (already legalised for the bus width)
//   i_idx       lane index, already truncated to size alignment
//   i_signed    1 = sign-extend loads
//   i_storeData right-justified store data
//   i_loadRaw   raw bus read data
//   o_storeData lane-replicated store data
//   o_be        byte enables
//   o_loadData  extended load result
// ---------------------------------------------------------------------------
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  mem_size_e                        i_size,
  input  logic [$clog2(DATA_W/8)-1:0]      i_idx,
  input  logic                             i_signed,
  input  logic [DATA_W-1:0]                i_storeData,
  input  logic [DATA_W-1:0]                i_loadRaw,
  output logic [DATA_W-1:0]                o_storeData,
  output logic [DATA_W/8-1:0]              o_be,
  output logic [DATA_W-1:0]                o_loadData
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_lowMask;
  logic              w_signBit;

  // Extension is done with a mask rather than a replication so that a
  // word access on a 32-bit bus needs no zero-width replication.
  always_comb begin
    w_shifted   = i_loadRaw >> {i_idx, 3'b000};
    o_be        = '0;
    o_storeData = '0;
    w_lowMask   = '1;
    w_signBit   = 1'b0;
    case (i_size)
      BYTE: begin
        o_be        = BE_W'(1) << i_idx;
        o_storeData = {BE_W{i_storeData[7:0]}};
        w_lowMask   = DATA_W'(8'hFF);
        w_signBit   = w_shifted[7];
      end
      HALF: begin
        o_be        = BE_W'(2'b11) << i_idx;
        o_storeData = {(BE_W/2){i_storeData[15:0]}};
        w_lowMask   = DATA_W'(16'hFFFF);
        w_signBit   = w_shifted[15];
      end
      WORD: begin
        o_be        = BE_W'(4'hF) << i_idx;
        o_storeData = {(DATA_W/32){i_storeData[31:0]}};
        w_lowMask   = DATA_W'(32'hFFFF_FFFF);
        w_signBit   = w_shifted[31];
      end
      default: begin
        o_be        = '1;
        o_storeData = i_storeData;
        w_lowMask   = '1;
        w_signBit   = 1'b0;
      end
    endcase
    o_loadData = (w_shifted & w_lowMask) |
                 ({DATA_W{i_signed & w_signBit}} & ~w_lowMask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Pipeline memory stage: takes an access from the EX/MEM latch, runs one
// request/acknowledge transaction on a variable-latency data bus and returns
// sized, extended load data together with a one-cycle done pulse.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   ExMe_out_*              access request from the EX/MEM latch
//   mem_data, done, fault   completion result back to the pipeline
//   stall                   hold request to the hazard unit
//   bus_*                   data bus master interface
// Build option:
//   MEM_MISALIGN_CHK_EN     when defined, accesses that are not size-aligned
//                           are faulted without touching the bus; otherwise
//                           the low address bits are dropped.
// ---------------------------------------------------------------------------
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   ExMe_out_alu_out,
  input  logic [DATA_W-1:0]   ExMe_out_reg_2,
  input  logic                ExMe_out_mem_wrt,
  input  logic                ExMe_out_mem_en,
  input  logic [1:0]          ExMe_out_mem_size,
  input  logic                ExMe_out_mem_signed,
  output logic [DATA_W-1:0]   mem_data,
  output logic                done,
  output logic                stall,
  output logic                fault,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_be,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int LB    = $clog2(BE_W);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  mem_state_e        r_state;
  mem_state_e        w_nextState;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busWe;
  logic [ADDR_W-1:0] r_busAddr;
  logic [DATA_W-1:0] r_busWdata;
  logic [BE_W-1:0]   r_busBe;
  mem_size_e         r_size;
  logic [LB-1:0]     r_idx;
  logic              r_signed;
  logic              r_wrt;
  logic [DATA_W-1:0] r_memData;
  logic              r_fault;

  mem_size_e         w_inSize;
  logic [LB-1:0]     w_sizeMask;
  logic [LB-1:0]     w_inIdx;
  logic              w_reject;
  logic              w_timeout;
  mem_size_e         w_alSize;
  logic [LB-1:0]     w_alIdx;
  logic              w_alSigned;
  logic [DATA_W-1:0] w_alWdata;
  logic [BE_W-1:0]   w_alBe;
  logic [DATA_W-1:0] w_alLoad;

  // A dword request on a 32-bit bus is downgraded to a word. The lane index
  // has its sub-size bits cleared so a misaligned access lands on the
  // enclosing aligned lane.
  always_comb begin
    w_inSize = mem_size_e'(ExMe_out_mem_size);
    if (DATA_W == 32 && w_inSize == DWORD) begin
      w_inSize = WORD;
    end
    w_sizeMask = LB'(size_bytes(w_inSize) - 4'd1);
    w_inIdx    = ExMe_out_alu_out[LB-1:0] & ~w_sizeMask;
  end

`ifdef MEM_MISALIGN_CHK_EN
  assign w_reject = (ExMe_out_alu_out[LB-1:0] & w_sizeMask) != '0;
`else
  assign w_reject = 1'b0;
`endif

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // In IDLE the aligner sees the live request so the bus registers can be
  // loaded on the accepting edge; afterwards it sees the latched access so
  // the returning read data is extracted with the right lane and size.
  assign w_alSize   = (r_state == IDLE) ? w_inSize : r_size;
  assign w_alIdx    = (r_state == IDLE) ? w_inIdx : r_idx;
  assign w_alSigned = (r_state == IDLE) ? ExMe_out_mem_signed : r_signed;

  mem_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .i_size      (w_alSize),
    .i_idx       (w_alIdx),
    .i_signed    (w_alSigned),
    .i_storeData (ExMe_out_reg_2),
    .i_loadRaw   (bus_rdata),
    .o_storeData (w_alWdata),
    .o_be        (w_alBe),
    .o_loadData  (w_alLoad)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. DONE always returns to IDLE, which is what gives
  // back-to-back accesses their single idle cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (ExMe_out_mem_en) begin
          w_nextState = w_reject ? DONE : REQ;
        end
      end
      REQ: begin
        if (bus_ack || w_timeout) begin
          w_nextState = DONE;
        end
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Access latches, bus registers, timeout counter and the result registers.
  // An ack takes priority over a timeout landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_busWe    <= 1'b0;
      r_busAddr  <= '0;
      r_busWdata <= '0;
      r_busBe    <= '0;
      r_size     <= BYTE;
      r_idx      <= '0;
      r_signed   <= 1'b0;
      r_wrt      <= 1'b0;
      r_memData  <= '0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ExMe_out_mem_en) begin
            r_cnt      <= '0;
            r_size     <= w_inSize;
            r_idx      <= w_inIdx;
            r_signed   <= ExMe_out_mem_signed;
            r_wrt      <= ExMe_out_mem_wrt;
            r_busAddr  <= {ExMe_out_alu_out[ADDR_W-1:LB], {LB{1'b0}}};
            r_busWdata <= w_alWdata;
            r_busBe    <= w_alBe;
            if (w_reject) begin
              r_busWe   <= 1'b0;
              r_fault   <= 1'b1;
              r_memData <= '0;
            end else begin
              r_busWe   <= ExMe_out_mem_wrt;
            end
          end
        end
        REQ: begin
          if (bus_ack) begin
            r_busWe   <= 1'b0;
            r_fault   <= bus_err;
            r_memData <= (r_wrt || bus_err) ? '0 : w_alLoad;
          end else if (w_timeout) begin
            r_busWe   <= 1'b0;
            r_fault   <= 1'b1;
            r_memData <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // bus_req is decoded from the state register so the asynchronous reset
  // drops it immediately.
  assign bus_req   = (r_state == REQ);
  assign bus_we    = r_busWe;
  assign bus_addr  = r_busAddr;
  assign bus_wdata = r_busWdata;
  assign bus_be    = r_busBe;
  assign done      = (r_state == DONE);
  assign fault     = r_fault;
  assign mem_data  = r_memData;
  assign stall     = ExMe_out_mem_en & ~done;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Directed self-checking bench for mem_access_unit. A 32-bit instance with a
// short timeout carries most of the sequence; a 64-bit instance covers the
// wider lanes and dword accesses. Expected completions are queued when an
// access is launched and popped when done is seen.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  typedef struct {
    string       tag;
    logic [63:0] memData;
    logic        fault;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  logic        clk;
  logic        rst_n;

  logic [31:0] exAddr;
  logic [31:0] exData;
  logic        exWrt, exEn, exSigned;
  logic [1:0]  exSize;
  logic [31:0] memData;
  logic        done, stall, fault, busReq, busWe;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic [3:0]  busBe;
  logic        busAck, busErr;
  logic [31:0] busRdata;

  logic [31:0] exAddr64;
  logic [63:0] exData64;
  logic        exWrt64, exEn64, exSigned64;
  logic [1:0]  exSize64;
  logic [63:0] memData64;
  logic        done64, stall64, fault64, busReq64, busWe64;
  logic [31:0] busAddr64;
  logic [63:0] busWdata64;
  logic [7:0]  busBe64;
  logic        busAck64, busErr64;
  logic [63:0] busRdata64;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(8)) u_dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ExMe_out_alu_out    (exAddr),
    .ExMe_out_reg_2      (exData),
    .ExMe_out_mem_wrt    (exWrt),
    .ExMe_out_mem_en     (exEn),
    .ExMe_out_mem_size   (exSize),
    .ExMe_out_mem_signed (exSigned),
    .mem_data            (memData),
    .done                (done),
    .stall               (stall),
    .fault               (fault),
    .bus_req             (busReq),
    .bus_we              (busWe),
    .bus_addr            (busAddr),
    .bus_wdata           (busWdata),
    .bus_be              (busBe),
    .bus_ack             (busAck),
    .bus_rdata           (busRdata),
    .bus_err             (busErr)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT_CYC(8)) u_dut64 (
    .clk                 (clk),
    .rst_n               (rst_n),
    .ExMe_out_alu_out    (exAddr64),
    .ExMe_out_reg_2      (exData64),
    .ExMe_out_mem_wrt    (exWrt64),
    .ExMe_out_mem_en     (exEn64),
    .ExMe_out_mem_size   (exSize64),
    .ExMe_out_mem_signed (exSigned64),
    .mem_data            (memData64),
    .done                (done64),
    .stall               (stall64),
    .fault               (fault64),
    .bus_req             (busReq64),
    .bus_we              (busWe64),
    .bus_addr            (busAddr64),
    .bus_wdata           (busWdata64),
    .bus_be              (busBe64),
    .bus_ack             (busAck64),
    .bus_rdata           (busRdata64),
    .bus_err             (busErr64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic driveReq(input bit sel64, input logic en, input logic [31:0] addr,
                          input logic [63:0] data, input logic wrt, input logic [1:0] size,
                          input logic sgn);
    if (sel64) begin
      exEn64 = en; exAddr64 = addr; exData64 = data;
      exWrt64 = wrt; exSize64 = size; exSigned64 = sgn;
    end else begin
      exEn = en; exAddr = addr; exData = data[31:0];
      exWrt = wrt; exSize = size; exSigned = sgn;
    end
  endtask

  task automatic driveBus(input bit sel64, input logic ack, input logic [63:0] rdata, input logic err);
    if (sel64) begin
      busAck64 = ack; busRdata64 = rdata; busErr64 = err;
    end else begin
      busAck = ack; busRdata = rdata[31:0]; busErr = err;
    end
  endtask

  // Launches one access, plays the bus slave (ack on the ackDelay-th request
  // cycle, never when 0) and checks the bus fields, stall, request length and
  // the queued completion.
  task automatic applyStimulus(input string tag, input bit sel64, input logic [31:0] addr,
                               input logic [63:0] data, input logic wrt, input logic [1:0] size,
                               input logic sgn, input int ackDelay, input logic [63:0] rdata,
                               input logic err, input int expReq, input logic [7:0] expBe,
                               input logic [63:0] expWdata, input logic [31:0] expAddr,
                               input logic [63:0] expMem, input logic expFault);
    int          reqCycles;
    bit          seenDone;
    logic        oReq, oDone, oStall, oWe, oFault;
    logic [7:0]  oBe;
    logic [63:0] oWdata, oMem;
    logic [31:0] oAddr;
    exp_t        e;
    @(negedge clk);
    driveReq(sel64, 1'b1, addr, data, wrt, size, sgn);
    expQ.push_back('{tag, expMem, expFault});
    reqCycles = 0;
    seenDone  = 0;
    for (int cyc = 0; cyc < 40 && !seenDone; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      oReq   = sel64 ? busReq64 : busReq;
      oDone  = sel64 ? done64 : done;
      oStall = sel64 ? stall64 : stall;
      oWe    = sel64 ? busWe64 : busWe;
      oFault = sel64 ? fault64 : fault;
      oBe    = sel64 ? busBe64 : {4'h0, busBe};
      oWdata = sel64 ? busWdata64 : {32'h0, busWdata};
      oMem   = sel64 ? memData64 : {32'h0, memData};
      oAddr  = sel64 ? busAddr64 : busAddr;
      if (oDone) begin
        seenDone = 1;
        checkOutput({tag, ".stallAtDone"}, {63'h0, oStall}, 64'h0);
        checkOutput({tag, ".reqAtDone"}, {63'h0, oReq}, 64'h0);
        checkOutput({tag, ".reqCycles"}, 64'(reqCycles), 64'(expReq));
        if (expQ.size() == 0) begin
          checkOutput({tag, ".queueEmpty"}, 64'h0, 64'h1);
        end else begin
          e = expQ.pop_front();
          checkOutput({e.tag, ".memData"}, oMem, e.memData);
          checkOutput({e.tag, ".fault"}, {63'h0, oFault}, {63'h0, e.fault});
        end
        driveBus(sel64, 1'b0, 64'h0, 1'b0);
      end else begin
        checkOutput({tag, ".stall"}, {63'h0, oStall}, 64'h1);
        if (oReq) begin
          reqCycles++;
          if (reqCycles == 1) begin
            checkOutput({tag, ".be"}, {56'h0, oBe}, {56'h0, expBe});
            checkOutput({tag, ".addr"}, {32'h0, oAddr}, {32'h0, expAddr});
            checkOutput({tag, ".we"}, {63'h0, oWe}, {63'h0, wrt});
            if (wrt) checkOutput({tag, ".wdata"}, oWdata, expWdata);
          end
          driveBus(sel64, (ackDelay != 0 && reqCycles == ackDelay), rdata, err);
        end else begin
          driveBus(sel64, 1'b0, 64'h0, 1'b0);
        end
      end
    end
    if (!seenDone) checkOutput({tag, ".doneTimeout"}, 64'h0, 64'h1);
    driveReq(sel64, 1'b0, 32'h0, 64'h0, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    #1;
    checkOutput({tag, ".donePulse"}, {63'h0, (sel64 ? done64 : done)}, 64'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    driveReq(1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 2'b00, 1'b0);
    driveReq(1'b1, 1'b0, 32'h0, 64'h0, 1'b0, 2'b00, 1'b0);
    driveBus(1'b0, 1'b0, 64'h0, 1'b0);
    driveBus(1'b1, 1'b0, 64'h0, 1'b0);
    #2;
    checkOutput("rst.memData", {32'h0, memData}, 64'h0);
    checkOutput("rst.done", {63'h0, done}, 64'h0);
    checkOutput("rst.fault", {63'h0, fault}, 64'h0);
    checkOutput("rst.busReq", {63'h0, busReq}, 64'h0);
    checkOutput("rst.busWe", {63'h0, busWe}, 64'h0);
    checkOutput("rst.busAddr", {32'h0, busAddr}, 64'h0);
    checkOutput("rst.busWdata", {32'h0, busWdata}, 64'h0);
    checkOutput("rst.busBe", {60'h0, busBe}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("wordStore", 0, 32'h100, 64'hDEADBEEF, 1, 2'b10, 0, 3, 64'h0, 0,
                  3, 8'h0F, 64'hDEADBEEF, 32'h100, 64'h0, 0);
    applyStimulus("byteStore", 0, 32'h101, 64'h000000A5, 1, 2'b00, 0, 1, 64'h0, 0,
                  1, 8'h02, 64'hA5A5A5A5, 32'h100, 64'h0, 0);
    applyStimulus("byteLoadS", 0, 32'h103, 64'h0, 0, 2'b00, 1, 1, 64'h80FF1234, 0,
                  1, 8'h08, 64'h0, 32'h100, 64'hFFFFFF80, 0);
    applyStimulus("byteLoadU", 0, 32'h103, 64'h0, 0, 2'b00, 0, 1, 64'h80FF1234, 0,
                  1, 8'h08, 64'h0, 32'h100, 64'h00000080, 0);
    applyStimulus("halfStore", 0, 32'h2, 64'h0000ABCD, 1, 2'b01, 0, 1, 64'h0, 0,
                  1, 8'h0C, 64'hABCDABCD, 32'h0, 64'h0, 0);
    applyStimulus("halfLoadS", 0, 32'h2, 64'h0, 0, 2'b01, 1, 1, 64'hABCD0000, 0,
                  1, 8'h0C, 64'h0, 32'h0, 64'hFFFFABCD, 0);
    applyStimulus("timeout", 0, 32'h40, 64'h0, 0, 2'b10, 0, 0, 64'h0, 0,
                  8, 8'h0F, 64'h0, 32'h40, 64'h0, 1);

    driveBus(1'b0, 1'b1, 64'hFFFFFFFF, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("lateAck.done", {63'h0, done}, 64'h0);
    checkOutput("lateAck.busReq", {63'h0, busReq}, 64'h0);
    driveBus(1'b0, 1'b0, 64'h0, 1'b0);

    applyStimulus("busErr", 0, 32'h10, 64'h0, 0, 2'b10, 0, 2, 64'h55, 1,
                  2, 8'h0F, 64'h0, 32'h10, 64'h0, 1);

    @(negedge clk);
    driveReq(1'b0, 1'b1, 32'h20, 64'h0, 1'b0, 2'b10, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("midRst.reqUp", {63'h0, busReq}, 64'h1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midRst.reqDrop", {63'h0, busReq}, 64'h0);
    checkOutput("midRst.noDone", {63'h0, done}, 64'h0);
    driveReq(1'b0, 1'b0, 32'h0, 64'h0, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput("postRst.done", {63'h0, done}, 64'h0);
      checkOutput("postRst.busReq", {63'h0, busReq}, 64'h0);
    end

`ifdef MEM_MISALIGN_CHK_EN
    applyStimulus("misalign", 0, 32'h101, 64'h0, 0, 2'b10, 0, 1, 64'h12345678, 0,
                  0, 8'h0F, 64'h0, 32'h100, 64'h0, 1);
`else
    applyStimulus("misalign", 0, 32'h101, 64'h0, 0, 2'b10, 0, 1, 64'h12345678, 0,
                  1, 8'h0F, 64'h0, 32'h100, 64'h12345678, 0);
`endif

    applyStimulus("w64Store", 1, 32'h104, 64'hCAFEF00D, 1, 2'b10, 0, 1, 64'h0, 0,
                  1, 8'hF0, 64'hCAFEF00DCAFEF00D, 32'h100, 64'h0, 0);
    applyStimulus("d64Store", 1, 32'h108, 64'h1122334455667788, 1, 2'b11, 0, 2, 64'h0, 0,
                  2, 8'hFF, 64'h1122334455667788, 32'h108, 64'h0, 0);
    applyStimulus("w64LoadS", 1, 32'h104, 64'h0, 0, 2'b10, 1, 1, 64'h8000000100000000, 0,
                  1, 8'hF0, 64'h0, 32'h100, 64'hFFFFFFFF80000001, 0);

    checkOutput("scoreboard.empty", 64'(expQ.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor to the pipeline memory stage.
- Takes the EX/MEM latch outputs (address, store data, control), runs a request/acknowledge transaction on a variable-latency data bus, and returns load data with a one-cycle done pulse.
- Adds byte/half/word(/dword) sizing with sign or zero extension, byte enables, a stall output to the hazard unit, a bus timeout and fault reporting.

Parameters:
- DATA_W, 32, data width; legal values 32 or 64.
- ADDR_W, 32, address width.
- TIMEOUT_CYC, 256, REQ cycles without bus_ack before the access is faulted; must be ≥2.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- ExMe_out_alu_out  input  ADDR_W  effective byte address
- ExMe_out_reg_2  input  DATA_W  store data, right-justified
- ExMe_out_mem_wrt  input  1  1=store, 0=load
- ExMe_out_mem_en  input  1  access request
- ExMe_out_mem_size  input  2  00 byte, 01 half, 10 word, 11 dword (DATA_W=64 only)
- ExMe_out_mem_signed  input  1  load sign-extends when 1
- mem_data  output  DATA_W  extended load data; 0 for stores and faults
- done  output  1  one-cycle completion pulse
- stall  output  1  hold the pipeline
- fault  output  1  valid with done; access failed
- bus_req  output  1  request, held until ack
- bus_we  output  1  write strobe
- bus_addr  output  ADDR_W  address, aligned to DATA_W/8
- bus_wdata  output  DATA_W  lane-replicated store data
- bus_be  output  DATA_W/8  byte enables
- bus_ack  input  1  transaction complete
- bus_rdata  input  DATA_W  read data, valid with ack
- bus_err  input  1  error, valid with ack

Behaviour:
- Reset, asynchronous: state IDLE. mem_data, done, fault, bus_req, bus_we, bus_addr, bus_wdata, bus_be and the timeout counter all go to 0. A reset mid-transaction drops bus_req immediately; no done is produced for that access.
- FSM states: IDLE, REQ, DONE.
  - IDLE → REQ when ExMe_out_mem_en=1.
    - Address, data, size, signed and wrt are latched.
    - bus_* registers are loaded and bus_req=1 from the next cycle.
  - REQ: bus_* held stable; counter increments each cycle.
    - bus_ack=1 → DONE. Load: mem_data ← extended lane; fault ← bus_err.
    - Counter reaches TIMEOUT_CYC-1 without ack → DONE with fault=1, mem_data=0; bus_req drops.
    - A late ack after a timeout is ignored.
  - DONE: done=1 for exactly one cycle, then unconditionally → IDLE. mem_en is not sampled in DONE.
- Timing:
  - stall = ExMe_out_mem_en & ~done (combinational).
  - Back-to-back accesses incur one IDLE cycle.
  - Minimum latency with zero-wait ack: done two cycles after mem_en is first seen.
- mem_data holds its value until the next load completes. A store completion sets it to 0.
- Lane index = addr[log2(DATA_W/8)-1:0].
  - byte: be = 1<<idx; wdata = byte replicated across all lanes.
  - half: be = 2'b11<<idx; wdata = half replicated.
  - word: be = 4'hF<<idx; wdata = word replicated (replication applies when DATA_W=64).
  - dword: be all ones.
  - Loads extract the addressed lane and extend to DATA_W.
- Size 11 with DATA_W=32 is treated as word.
- The pipeline must hold inputs stable while stall=1; inputs are only sampled in IDLE.

Optional Feature:
- MEM_MISALIGN_CHK_EN.
- Defined: an access whose address is not size-aligned never raises bus_req. FSM goes IDLE → DONE directly, with fault=1 and mem_data=0.
- Undefined: misaligned low address bits below the access size are ignored; the access uses the truncated aligned address and completes normally.

Decomposition:
- Package mem_pkg holds:
  - typedef enum mem_size_e: BYTE, HALF, WORD, DWORD
  - typedef enum mem_state_e: IDLE, REQ, DONE
  - function size_bytes(mem_size_e)
- Sub-module mem_lane_align: purely combinational. Generates store replication and byte enables, and does load lane extraction and sign/zero extension. Parametrised on DATA_W.
- mem_access_unit contains the FSM, the latches and the timeout counter.

Test Plan:
- Word store, addr 0x100, data 0xDEADBEEF, ack after 3 cycles -> bus_req high 3 cycles, be=4'hF, wdata=0xDEADBEEF, one done pulse, mem_data=0, fault=0, stall high until done.
- Signed byte load, addr 0x103, rdata 0x80FF_1234, zero-wait ack -> be=4'b1000, mem_data=0xFFFF_FF80; repeat unsigned -> 0x0000_0080.
- Half store, addr 0x2, data 0x0000_ABCD -> be=4'b1100, wdata=0xABCD_ABCD; half load same address, rdata 0xABCD_0000, signed -> 0xFFFF_ABCD.
- No ack, TIMEOUT_CYC=8 -> bus_req high 8 cycles then drops, done=1, fault=1, mem_data=0; late ack ignored.
- Ack with bus_err=1 -> done with fault=1. Then rst_n pulled low mid-REQ on a second access -> bus_req drops the same cycle, no done, IDLE after release.
- MEM_MISALIGN_CHK_EN defined: word load at addr 0x101 -> no bus_req, done+fault next cycle. Undefined: bus_addr=0x100, normal completion. DATA_W=64 dword store sets be=8'hFF.
